// File: rtl/bcd_string2ascii_if.sv
// Handshake bundle for bcd_string2ascii.
//   slave  : converter side; receives bcd/start/ascii_ready and drives
//            busy, ascii, ascii_valid, last, err.
//   master : requester/consumer side; the mirror image of slave.
// Parameter DIGITS sets the packed BCD width (4*DIGITS bits). It must match
// the DIGITS of the converter bound to this interface.
interface bcd_string2ascii_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] bcd;
    logic                start;
    logic                busy;
    logic [6:0]          ascii;
    logic                ascii_valid;
    logic                ascii_ready;
    logic                last;
    logic                err;

    modport master (
        output bcd, start, ascii_ready,
        input  busy, ascii, ascii_valid, last, err
    );

    modport slave (
        input  bcd, start, ascii_ready,
        output busy, ascii, ascii_valid, last, err
    );
endinterface

// File: rtl/bcd_string2ascii.sv
// Packed BCD to ASCII string serializer.
// Captures a DIGITS-wide packed BCD value on start and streams it out MSD
// first as ASCII characters over a valid/ready handshake. A '.' is inserted
// after the digit at position DP_POS (LSD = position 0) when DP_POS > 0.
// Illegal digits (10..15) are emitted as 'A' and raise the sticky err flag.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bcd_string2ascii_if.slave (bcd, start, busy, ascii, ascii_valid,
//          ascii_ready, last, err)
//
// Build option: define BCD_STRING2ASCII_BLANK_EN to print leading zeros of
// the integer part as spaces (integer LSD and fractional digits are never
// blanked).
module bcd_string2ascii #(
    parameter int DIGITS = 4,
    parameter int DP_POS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_string2ascii_if.slave   bus
);

    localparam int LEN = (DP_POS > 0) ? DIGITS + 1 : DIGITS;
    localparam int IW  = $clog2(LEN + 1);
    localparam int PW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);
    // Character index at which the decimal point sits.
    localparam logic [IW-1:0] DP_IDX   = IW'(DIGITS - DP_POS);
    localparam logic [IW-1:0] DIG_N    = IW'(DIGITS);

`ifdef BCD_STRING2ASCII_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state_q, state_d;
    logic [DIGITS-1:0][3:0]  cap_q;
    logic [DIGITS-1:0][3:0]  src;
    logic [IW-1:0]           idx_q, idx_d;
    logic [6:0]              ascii_q, ascii_d;
    logic                    last_q, err_q;
    logic                    load, adv, done;
    logic [DIGITS-1:0]       blank, bad;
    logic [DIGITS-1:0][6:0]  dig_char;
    logic [PW-1:0]           pos;

    // The first character must be ready on the capture edge, so in IDLE the
    // decoder looks at the live input; afterwards at the captured copy.
    assign src = (state_q == IDLE) ? bus.bcd : cap_q;

    // Per-digit decode. A digit is blanked when it and every more
    // significant digit are zero; an illegal digit is non-zero so it stops
    // blanking naturally.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        if (BLANK_EN && (g > DP_POS)) begin : g_blank
            assign blank[g] = (src[DIGITS-1:g] == '0);
        end else begin : g_noblank
            assign blank[g] = 1'b0;
        end
        assign bad[g]      = (src[g] > 4'd9);
        assign dig_char[g] = bad[g]   ? 7'h41 :
                             blank[g] ? 7'h20 :
                                        {3'b011, src[g]};
    end

    assign idx_d = load ? '0 : idx_q + 1'b1;

    // Map character index to digit position, skipping the '.' slot.
    always_comb begin
        pos = '0;
        if ((DP_POS > 0) && (idx_d > DP_IDX))
            pos = PW'(DIG_N - idx_d);
        else
            pos = PW'(DIG_N - idx_d - 1'b1);
        ascii_d = ((DP_POS > 0) && (idx_d == DP_IDX)) ? 7'h2E : dig_char[pos];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SEND;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (bus.ascii_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q   <= '0;
            idx_q   <= '0;
            ascii_q <= 7'h00;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (load) begin
            cap_q   <= bus.bcd;
            idx_q   <= '0;
            ascii_q <= ascii_d;
            last_q  <= (LAST_IDX == '0);
            err_q   <= |bad;
        end else if (adv) begin
            idx_q   <= idx_d;
            ascii_q <= ascii_d;
            last_q  <= (idx_d == LAST_IDX);
        end else if (done) begin
            // ascii keeps the final character; only last drops.
            last_q  <= 1'b0;
        end
    end

    assign bus.busy        = (state_q == SEND);
    assign bus.ascii_valid = (state_q == SEND);
    assign bus.ascii       = ascii_q;
    assign bus.last        = last_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_bcd_string2ascii.sv
// Self-checking bench for bcd_string2ascii. Two instances share clk/rst_n:
// unit 0 uses DIGITS=4/DP_POS=3, unit 1 uses DIGITS=4/DP_POS=0. Expected
// strings come from a queue-based model of the character rules.
module tb_bcd_string2ascii;

`ifdef BCD_STRING2ASCII_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_string2ascii_if #(.DIGITS(4)) if0 ();
    bcd_string2ascii_if #(.DIGITS(4)) if1 ();

    bcd_string2ascii #(.DIGITS(4), .DP_POS(3)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    bcd_string2ascii #(.DIGITS(4), .DP_POS(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    logic [15:0] bcd_d [2];
    logic        start_d [2];
    logic        rdy_d [2];
    logic [6:0]  asc_o [2];
    logic        vld_o [2];
    logic        last_o [2];
    logic        busy_o [2];
    logic        err_o [2];

    assign if0.bcd = bcd_d[0];  assign if0.start = start_d[0];  assign if0.ascii_ready = rdy_d[0];
    assign if1.bcd = bcd_d[1];  assign if1.start = start_d[1];  assign if1.ascii_ready = rdy_d[1];
    assign asc_o[0] = if0.ascii;  assign vld_o[0] = if0.ascii_valid;  assign last_o[0] = if0.last;
    assign busy_o[0] = if0.busy;  assign err_o[0] = if0.err;
    assign asc_o[1] = if1.ascii;  assign vld_o[1] = if1.ascii_valid;  assign last_o[1] = if1.last;
    assign busy_o[1] = if1.busy;  assign err_o[1] = if1.err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [6:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference string: walk digits MSD..LSD, blank while still in the run of
    // leading zeros above the integer LSD, append '.' after digit dp.
    task automatic build_exp(input logic [15:0] v, input int dp);
        int d [4];
        bit lead;
        logic [6:0] c;
        lead = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) d[i] = int'((v >> (4*i)) & 16'hF);
        for (int p = 3; p >= 0; p--) begin
            if (d[p] > 9) c = 7'h41;
            else          c = 7'(48 + d[p]);
            if (d[p] != 0) lead = 1'b0;
            if (BLANK && lead && p > dp) c = 7'h20;
            exp_q.push_back(c);
            if (dp > 0 && p == dp) exp_q.push_back(7'h2E);
        end
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        int k;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            k = int'($urandom_range(0, 19));
            if (k < 6)        v[4*i +: 4] = 4'd0;
            else if (k == 19) v[4*i +: 4] = 4'($urandom_range(10, 15));
            else              v[4*i +: 4] = 4'($urandom_range(1, 9));
        end
        return v;
    endfunction

    // mode 0: ready always 1; mode 1: random ready; mode 2: 3-cycle stall on
    // the second character. Modes 1/2 also pulse start and change bcd mid-string.
    task automatic run_str(input int u, input logic [15:0] v, input int mode);
        int n, cyc, len, stall_cnt;
        bit stalled, r, exp_err;
        logic [6:0] held_a;
        logic held_l;
        n = 0; cyc = 0; stall_cnt = 0; stalled = 1'b0;
        held_a = '0; held_l = 1'b0;
        build_exp(v, (u == 0) ? 3 : 0);
        len = exp_q.size();
        exp_err = 1'b0;
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) exp_err = 1'b1;

        @(negedge clk);
        bcd_d[u] = v; start_d[u] = 1'b1; rdy_d[u] = 1'b1;
        @(negedge clk);
        start_d[u] = 1'b0;
        chk("busy", 32'(busy_o[u]), 1);
        chk("err", 32'(err_o[u]), 32'(exp_err));
        chk("first_vld", 32'(vld_o[u]), 1);

        while (n < len && cyc < 200) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 2) != 0);
                default: r = !(n == 1 && stall_cnt < 3);
            endcase
            if (mode == 2 && !r) stall_cnt++;
            if (mode != 0) begin
                start_d[u] = ($urandom_range(0, 2) == 0);
                bcd_d[u]   = 16'($urandom);
            end
            rdy_d[u] = r;
            if (stalled && vld_o[u]) begin
                chk("hold_ascii", 32'(asc_o[u]), 32'(held_a));
                chk("hold_last", 32'(last_o[u]), 32'(held_l));
            end
            if (!vld_o[u]) begin
                chk("vld_mid", 32'(vld_o[u]), 1);
                n = len;
            end else if (r) begin
                chk("char", 32'(asc_o[u]), 32'(exp_q[n]));
                chk("last", 32'(last_o[u]), 32'(n == len - 1));
                n++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held_a = asc_o[u];
                held_l = last_o[u];
            end
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 200) chk("timeout", 32'(n), 32'(len));
        start_d[u] = 1'b0;
        rdy_d[u] = ($urandom_range(0, 1) != 0);
        chk("vld_end", 32'(vld_o[u]), 0);
        chk("busy_end", 32'(busy_o[u]), 0);
        chk("last_end", 32'(last_o[u]), 0);
        chk("ascii_keep", 32'(asc_o[u]), 32'(exp_q[len-1]));
        chk("err_keep", 32'(err_o[u]), 32'(exp_err));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            bcd_d[i] = '0; start_d[i] = 1'b0; rdy_d[i] = 1'b0;
        end
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ascii", 32'(asc_o[i]), 0);
            chk("rst_vld", 32'(vld_o[i]), 0);
            chk("rst_busy", 32'(busy_o[i]), 0);
            chk("rst_last", 32'(last_o[i]), 0);
            chk("rst_err", 32'(err_o[i]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_str(0, 16'h3300, 0);
        run_str(1, 16'h0125, 0);
        run_str(0, 16'h0005, 0);
        run_str(1, 16'h0000, 0);
        run_str(0, 16'h12A4, 0);
        run_str(0, 16'h1234, 0);
        run_str(0, 16'h0907, 2);
        run_str(1, 16'h00F0, 2);

        for (int t = 0; t < 40; t++)
            run_str(t % 2, rand_bcd(), int'($urandom_range(0, 2)));

        // Asynchronous reset during the third character.
        @(negedge clk);
        bcd_d[0] = 16'h4567; start_d[0] = 1'b1; rdy_d[0] = 1'b1;
        @(negedge clk);
        start_d[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_char", 32'(asc_o[0]), 32'h35);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ascii", 32'(asc_o[0]), 0);
        chk("arst_vld", 32'(vld_o[0]), 0);
        chk("arst_busy", 32'(busy_o[0]), 0);
        chk("arst_last", 32'(last_o[0]), 0);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_vld", 32'(vld_o[0]), 0);
            chk("post_rst_busy", 32'(busy_o[0]), 0);
        end
        run_str(0, 16'h0987, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
